// File: rtl/alu_exec_unit.sv
// EX-stage ALU with merged ALUOp/funct decode. Single-cycle ops complete one edge after accept;
// multiply iterates MUL_BPC bits per edge and holds ready_o low until it finishes.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_BPC = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       ALUOp_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             illegal_o
);

  localparam int N  = WIDTH / MUL_BPC;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_CNT = CW'(N);

  typedef enum logic {IDLE, MUL} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_MUL, OP_ILL
  } op_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, illegal_q, illegal_d, valid_q, valid_d;

  op_t              op;
  logic [WIDTH-1:0] alu_res, step_acc;

  always_comb begin
    op = OP_ADD;
    unique case (ALUOp_i)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b11: op = OP_OR;
      default: begin
        case (funct_i)
          6'b100000: op = OP_ADD;
          6'b100010: op = OP_SUB;
          6'b100100: op = OP_AND;
          6'b100101: op = OP_OR;
          6'b100110: op = OP_XOR;
          6'b100111: op = OP_NOR;
          6'b101010: op = OP_SLT;
          6'b011000: op = OP_MUL;
          default:   op = OP_ILL;
        endcase
      end
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = data1_i + data2_i;
      OP_SUB:  alu_res = data1_i - data2_i;
      OP_AND:  alu_res = data1_i & data2_i;
      OP_OR:   alu_res = data1_i | data2_i;
      OP_XOR:  alu_res = data1_i ^ data2_i;
      OP_NOR:  alu_res = ~(data1_i | data2_i);
      OP_SLT:  alu_res = ($signed(data1_i) < $signed(data2_i)) ? WIDTH'(1) : '0;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step over the low MUL_BPC multiplier bits.
  always_comb begin
    step_acc = acc_q;
    for (int b = 0; b < MUL_BPC; b++) begin
      if (mplier_q[b]) step_acc = step_acc + (mcand_q << b);
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i && !flush_i) begin
          if (op == OP_MUL) begin
            mcand_d  = data1_i;
            mplier_d = data2_i;
            acc_d    = '0;
            cnt_d    = N_CNT;
            state_d  = MUL;
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = (op == OP_ILL);
            valid_d   = 1'b1;
          end
        end
      end
      default: begin
        acc_d    = step_acc;
        mcand_d  = mcand_q << MUL_BPC;
        mplier_d = mplier_q >> MUL_BPC;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d  = step_acc;
          zero_d    = (step_acc == '0);
          illegal_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = IDLE;
        end
      end
    endcase
    // Flush drops whatever is in flight but leaves the visible result untouched.
    if (flush_i) begin
      state_d   = IDLE;
      valid_d   = 1'b0;
      cnt_d     = '0;
      acc_d     = '0;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      valid_q   <= valid_d;
    end
  end

  assign ready_o   = (state_q == IDLE);
  assign valid_o   = valid_q;
  assign result_o  = result_q;
  assign zero_o    = zero_q;
  assign illegal_o = illegal_q;

endmodule
